seven_seg_display_arbiter: RTL and testbench

//  Shares the two-digit multiplexed seven-segment display between CLIENTS requesters.

---
 rtl/seven_seg_pkg.sv | 13 +
 rtl/rr_priority_picker.sv | 32 +++
 rtl/seven_seg_display_arbiter.sv | 130 +++++++++++++
 tb/tb_seven_seg_display_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment display arbiter.
// The blank gap between slots is enabled with SEVEN_SEG_ARB_BLANK_GAP_EN.
package seven_seg_pkg;
  localparam int CODE_W   = 8;
  localparam int POINTS_W = 2;
  localparam logic [CODE_W-1:0] IDLE_CODE_DEFAULT = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;
endpackage

// File: rtl/rr_priority_picker.sv
// Combinational rotate-priority select: first requester at or after ptr,
// wrapping past N-1 to 0. Reusable for any shared Pmod resource.
module rr_priority_picker #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] winner,
  output logic                 found
);
  localparam int IW = $clog2(N);

  int             w_sum;
  logic [IW-1:0]  w_idx;

  // Scan from the farthest offset down so the nearest requester is the last write.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    w_sum  = 0;
    w_idx  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_sum = int'(ptr) + i;
      if (w_sum >= N) w_sum = w_sum - N;
      w_idx = IW'(w_sum);
      if (req[w_idx]) begin
        found  = 1'b1;
        winner = w_idx;
      end
    end
  end
endmodule

// File: rtl/seven_seg_display_arbiter.sv
// Round-robin arbiter sharing a two-digit seven-segment display between clients.
// Define SEVEN_SEG_ARB_BLANK_GAP_EN to insert a blank GAP state after every slot.
module seven_seg_display_arbiter
  import seven_seg_pkg::*;
#(
  parameter int                CLIENTS   = 4,
  parameter int                HOLD_BITS = 24,
  parameter logic [CODE_W-1:0] IDLE_CODE = IDLE_CODE_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CLIENTS-1:0]            req,
  input  logic [CODE_W*CLIENTS-1:0]     req_code,
  input  logic [POINTS_W*CLIENTS-1:0]   req_points,
  output logic [CLIENTS-1:0]            ack,
  output logic [CLIENTS-1:0]            done,
  output logic [CODE_W-1:0]             code,
  output logic [POINTS_W-1:0]           points,
  output logic                          busy,
  output logic [$clog2(CLIENTS)-1:0]    owner,
  output arb_state_e                    o_dbg_state
);
  localparam int OWN_W = $clog2(CLIENTS);
`ifdef SEVEN_SEG_ARB_BLANK_GAP_EN
  localparam logic [HOLD_BITS-1:0] GAP_LAST = HOLD_BITS'((1 << (HOLD_BITS - 4)) - 1);
`endif

  arb_state_e            r_state, w_state_next;
  logic [HOLD_BITS-1:0]  r_cnt, w_cnt_next;
  logic [OWN_W-1:0]      r_ptr, w_ptr_next;
  logic [OWN_W-1:0]      r_owner, w_owner_next;
  logic [CODE_W-1:0]     r_code, w_code_next;
  logic [POINTS_W-1:0]   r_points, w_points_next;
  logic                  r_busy, w_busy_next;
  logic [CLIENTS-1:0]    r_ack, w_ack_next;
  logic [CLIENTS-1:0]    r_done, w_done_next;
  logic [OWN_W-1:0]      w_winner;
  logic                  w_found;

  rr_priority_picker #(.N(CLIENTS)) u_picker (
    .req    (req),
    .ptr    (r_ptr),
    .winner (w_winner),
    .found  (w_found)
  );

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt;
    w_ptr_next    = r_ptr;
    w_owner_next  = r_owner;
    w_code_next   = r_code;
    w_points_next = r_points;
    w_busy_next   = r_busy;
    w_ack_next    = '0;
    w_done_next   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_next          = ST_SHOW;
          w_ack_next[w_winner]  = 1'b1;
          w_owner_next          = w_winner;
          w_busy_next           = 1'b1;
          w_code_next           = req_code[CODE_W*w_winner +: CODE_W];
          w_points_next         = req_points[POINTS_W*w_winner +: POINTS_W];
          w_cnt_next            = '0;
        end
      end
      ST_SHOW: begin
        w_cnt_next = r_cnt + 1'b1;
        // Expiry and withdraw share one exit, so a simultaneous drop pulses done once.
        if ((&r_cnt) || !req[r_owner]) begin
          w_done_next[r_owner] = 1'b1;
          w_ptr_next    = (r_owner == OWN_W'(CLIENTS - 1)) ? '0 : r_owner + 1'b1;
          w_code_next   = IDLE_CODE;
          w_points_next = '0;
          w_busy_next   = 1'b0;
          w_cnt_next    = '0;
`ifdef SEVEN_SEG_ARB_BLANK_GAP_EN
          w_state_next  = ST_GAP;
`else
          w_state_next  = ST_IDLE;
`endif
        end
      end
`ifdef SEVEN_SEG_ARB_BLANK_GAP_EN
      ST_GAP: begin
        w_cnt_next = r_cnt + 1'b1;
        if (r_cnt == GAP_LAST) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
        end
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_ptr    <= '0;
      r_owner  <= '0;
      r_code   <= IDLE_CODE;
      r_points <= '0;
      r_busy   <= 1'b0;
      r_ack    <= '0;
      r_done   <= '0;
    end else begin
      r_state  <= w_state_next;
      r_cnt    <= w_cnt_next;
      r_ptr    <= w_ptr_next;
      r_owner  <= w_owner_next;
      r_code   <= w_code_next;
      r_points <= w_points_next;
      r_busy   <= w_busy_next;
      r_ack    <= w_ack_next;
      r_done   <= w_done_next;
    end
  end

  assign ack         = r_ack;
  assign done        = r_done;
  assign code        = r_code;
  assign points      = r_points;
  assign busy        = r_busy;
  assign owner       = r_owner;
  assign o_dbg_state = r_state;
endmodule

// File: tb/tb_seven_seg_display_arbiter.sv
// Directed and randomized bench for seven_seg_display_arbiter (4 clients, 16-cycle slot)
// with a slot-level reference model and a grant scoreboard.
module tb_seven_seg_display_arbiter;
  import seven_seg_pkg::*;

  localparam int CLIENTS   = 4;
  localparam int HOLD_BITS = 4;
  localparam int SLOT      = 1 << HOLD_BITS;
`ifdef SEVEN_SEG_ARB_BLANK_GAP_EN
  localparam int GAP = 1 << (HOLD_BITS - 4);
`else
  localparam int GAP = 0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_code;
  logic [7:0]  req_points;
  logic [3:0]  ack, done;
  logic [7:0]  code;
  logic [1:0]  points;
  logic        busy;
  logic [1:0]  owner;
  arb_state_e  dbg_state;

  always #5 clk = ~clk;

  seven_seg_display_arbiter #(.CLIENTS(CLIENTS), .HOLD_BITS(HOLD_BITS)) dut (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .req_code    (req_code),
    .req_points  (req_points),
    .ack         (ack),
    .done        (done),
    .code        (code),
    .points      (points),
    .busy        (busy),
    .owner       (owner),
    .o_dbg_state (dbg_state)
  );

  // ---------------- scoreboard / counters ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [9:0]  exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model (slot level) ----------------
  // A slot is an owner plus an age; it ends when age reaches SLOT-1 or the owner withdraws.
  bit          m_busy = 1'b0;
  logic [1:0]  m_owner = '0;
  int          m_age = 0;
  int          m_gap = 0;
  int          m_ptr = 0;
  logic [7:0]  m_code = 8'h00;
  logic [1:0]  m_points = 2'b00;
  logic [3:0]  m_ack, m_done;

  task automatic model_step();
    int c;
    bit got;
    m_ack  = '0;
    m_done = '0;
    if (reset) begin
      m_busy = 1'b0; m_owner = '0; m_ptr = 0; m_gap = 0;
      m_code = 8'h00; m_points = 2'b00;
      exp_q.delete();
    end else if (m_busy) begin
      if (m_age == SLOT - 1 || !req[m_owner]) begin
        m_done[m_owner] = 1'b1;
        m_busy   = 1'b0;
        m_ptr    = (int'(m_owner) + 1) % CLIENTS;
        m_code   = 8'h00;
        m_points = 2'b00;
        m_gap    = GAP;
      end else begin
        m_age++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      got = 1'b0;
      for (int k = 0; k < CLIENTS; k++) begin
        c = (m_ptr + k) % CLIENTS;
        if (!got && req[c[1:0]]) begin
          got      = 1'b1;
          m_busy   = 1'b1;
          m_owner  = c[1:0];
          m_age    = 0;
          m_code   = req_code[8*c +: 8];
          m_points = req_points[2*c +: 2];
          m_ack[c[1:0]] = 1'b1;
          exp_q.push_back({m_points, m_code});
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [9:0] e;
    chk("code", 32'(code), 32'(m_code));
    chk("points", 32'(points), 32'(m_points));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("ack", 32'(ack), 32'(m_ack));
    chk("done", 32'(done), 32'(m_done));
    chk("ack_done_overlap", 32'(ack & done), 32'(0));
    if (m_busy) chk("owner", 32'(owner), 32'(m_owner));
    if (ack !== 4'b0000) begin
      chk("sb_depth", 32'(exp_q.size()), 32'(1));
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_capture", 32'({points, code}), 32'(e));
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  function automatic int oh_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  int n_shown;
  bit seen;
  int cyc, last_done, n_acks;
  int rr_got[5];
  int rr_exp[5] = '{0, 1, 2, 3, 0};

  initial begin
    // Reset values
    reset = 1'b1; req = '0; req_code = '0; req_points = '0;
    tick(); tick();
    chk("rst_owner", 32'(owner), 32'(0));
    chk("rst_code", 32'(code), 32'(8'h00));
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    tick();

    // Single client: code A5 shown for a full slot
    req_code[23:16] = 8'hA5; req_points[5:4] = 2'b01; req = 4'b0100;
    tick();
    chk("single_ack", 32'(ack), 32'(4'b0100));
    n_shown = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (code === 8'hA5) n_shown++;
      tick();
      if (done !== 4'b0000) seen = 1'b1;
    end
    req = '0;
    chk("single_len", 32'(n_shown), 32'(SLOT));
    chk("single_done", 32'(done), 32'(4'b0100));
    chk("single_idle_code", 32'(code), 32'(8'h00));
    tick(); tick();

    // Round-robin from a fresh pointer
    reset = 1'b1; tick(); reset = 1'b0;
    req_code = {8'h44, 8'h33, 8'h22, 8'h11}; req_points = 8'b11_10_01_00;
    req = 4'b1111;
    cyc = 0; last_done = 0; n_acks = 0;
    for (int i = 0; i < 200 && n_acks < 5; i++) begin
      tick(); cyc++;
      if (done !== 4'b0000) last_done = cyc;
      if (ack !== 4'b0000) begin
        if (n_acks > 0) chk("rr_spacing", 32'(cyc - last_done), 32'(1 + GAP));
        rr_got[n_acks] = oh_idx(ack);
        n_acks++;
      end
    end
    chk("rr_count", 32'(n_acks), 32'(5));
    for (int i = 0; i < 5; i++) chk("rr_order", 32'(rr_got[i]), 32'(rr_exp[i]));
    req = '0;
    tick(); tick(); tick();

    // Reset in the middle of a slot; no done, pointer back to 0
    req = 4'b1000;
    for (int i = 0; i < 12 && !busy; i++) tick();
    for (int i = 0; i < 7; i++) tick();
    reset = 1'b1;
    tick();
    chk("rstmid_done", 32'(done), 32'(0));
    chk("rstmid_busy", 32'(busy), 32'(0));
    chk("rstmid_code", 32'(code), 32'(8'h00));
    chk("rstmid_owner", 32'(owner), 32'(0));
    reset = 1'b0; req = '0;
    tick();
    req = 4'b0101;
    tick();
    chk("rstmid_ptr", 32'(ack), 32'(4'b0001));
    req = '0;
    tick(); tick(); tick();

    // Withdraw: client 1 drops at slot cycle 5, client 2 follows
    req = 4'b0110;
    tick();
    chk("wd_ack1", 32'(ack), 32'(4'b0010));
    for (int i = 0; i < 5; i++) tick();
    req[1] = 1'b0;
    tick();
    chk("wd_done1", 32'(done), 32'(4'b0010));
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (ack !== 4'b0000) seen = 1'b1;
    end
    chk("wd_ack2", 32'(ack), 32'(4'b0100));
    req = '0;
    tick(); tick(); tick();

    // Capture: code changes mid-slot but display holds the captured value
    req_code[31:24] = 8'h12;
    req = 4'b1000;
    tick();
    chk("cap_ack", 32'(ack), 32'(4'b1000));
    n_shown = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (code === 8'h12) n_shown++;
      if (i == 3) req_code[31:24] = 8'h34;
      tick();
      if (done !== 4'b0000) seen = 1'b1;
    end
    req = '0;
    chk("cap_len", 32'(n_shown), 32'(SLOT));
    tick(); tick();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      req_code   = $urandom();
      req_points = 8'($urandom());
      tick();
    end
    reset = 1'b0; req = '0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
